// File: rtl/square_move_serializer_if.sv
// Valid/ready move stream from a square's serializer to the move collector.
interface square_move_serializer_if #(
    parameter int N_DIR  = 16,
    parameter int MOVE_W = 32
);
    localparam int IDX_W = $clog2(N_DIR);

    logic              out_valid;
    logic              out_ready;
    logic [MOVE_W-1:0] out_move;
    logic [IDX_W-1:0]  out_index;

    modport master (output out_valid, output out_move, output out_index, input out_ready);
    modport slave  (input out_valid, input out_move, input out_index, output out_ready);
endinterface

// File: rtl/square_move_serializer.sv
// Snapshots N_DIR move words on start and streams the non-empty ones over a valid/ready link.
// Optional capture-first ordering: define SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN.
module square_move_serializer #(
    parameter int N_DIR   = 16,
    parameter int MOVE_W  = 32,
    parameter int CAP_LSB = 18,
    parameter int CAP_W   = 6,
    localparam int IDX_W  = $clog2(N_DIR),
    localparam int CNT_W  = $clog2(N_DIR + 1)
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_DIR*MOVE_W-1:0]   move_in,
    square_move_serializer_if.master  mv,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          move_count
);
    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

    state_t            state;
    logic [MOVE_W-1:0] snap [N_DIR];
    logic [N_DIR-1:0]  mask;
    logic [CNT_W-1:0]  cnt;

    logic [N_DIR-1:0]  onehot, acc_mask, start_mask, src_mask, pick_mask;
    logic [IDX_W-1:0]  nsel;
    logic [MOVE_W-1:0] nmove;
`ifdef SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN
    logic [N_DIR-1:0]  cap, start_cap, src_cap, acc_cap;
`endif

    // Next selection is computed from the post-acceptance mask so the following move
    // can be registered on the same edge, keeping one move per cycle.
    always_comb begin
        onehot = '0;
        onehot[mv.out_index] = 1'b1;
        acc_mask = mask & ~onehot;
        for (int unsigned i = 0; i < N_DIR; i++)
            start_mask[i] = |move_in[i*MOVE_W +: MOVE_W];
        src_mask = (state == S_IDLE) ? start_mask : acc_mask;
`ifdef SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN
        for (int unsigned i = 0; i < N_DIR; i++)
            start_cap[i] = |move_in[i*MOVE_W+CAP_LSB +: CAP_W];
        acc_cap   = cap & ~onehot;
        src_cap   = (state == S_IDLE) ? start_cap : acc_cap;
        pick_mask = (|(src_mask & src_cap)) ? (src_mask & src_cap) : src_mask;
`else
        pick_mask = src_mask;
`endif
        nsel = '0;
        for (int unsigned i = N_DIR; i > 0; i--)
            if (pick_mask[i-1]) nsel = IDX_W'(i - 1);
        nmove = (state == S_IDLE) ? move_in[nsel*MOVE_W +: MOVE_W] : snap[nsel];
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state        <= S_IDLE;
            mask         <= '0;
            cnt          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            move_count   <= '0;
            mv.out_valid <= 1'b0;
            mv.out_move  <= '0;
            mv.out_index <= '0;
            for (int unsigned i = 0; i < N_DIR; i++) snap[i] <= '0;
`ifdef SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN
            cap          <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        for (int unsigned i = 0; i < N_DIR; i++)
                            snap[i] <= move_in[i*MOVE_W +: MOVE_W];
                        mask <= start_mask;
`ifdef SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN
                        cap  <= start_cap;
`endif
                        cnt  <= '0;
                        busy <= 1'b1;
                        if (|start_mask) begin
                            state        <= S_EMIT;
                            mv.out_valid <= 1'b1;
                            mv.out_move  <= nmove;
                            mv.out_index <= nsel;
                        end else begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            move_count <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    // abort outranks a same-cycle acceptance
                    if (abort) begin
                        state        <= S_IDLE;
                        mask         <= '0;
`ifdef SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN
                        cap          <= '0;
`endif
                        mv.out_valid <= 1'b0;
                        busy         <= 1'b0;
                    end else if (mv.out_ready) begin
                        mask <= acc_mask;
`ifdef SQUARE_MOVE_SERIALIZER_CAPTURE_FIRST_EN
                        cap  <= acc_cap;
`endif
                        cnt  <= cnt + 1'b1;
                        if (|acc_mask) begin
                            mv.out_move  <= nmove;
                            mv.out_index <= nsel;
                        end else begin
                            state        <= S_DONE;
                            mv.out_valid <= 1'b0;
                            done         <= 1'b1;
                            move_count   <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
